// File: rtl/fixed_pkg.sv
// Fixed-point helpers shared by the saturating datapath stages.
package fixed_pkg;

    function automatic logic [7:0] sat_int8(input logic signed [48:0] v);
        logic [7:0] res;
        if (v > 49'sd127) begin
            res = 8'h7f;
        end else if (v < -49'sd128) begin
            res = 8'h80;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/npu_pkg.sv
// Shared NPU datapath widths and the requantization stage state type.
package npu_pkg;

    localparam int ACC_W  = 32;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } requant_state_t;

endpackage

// File: rtl/requant_unit.sv
// Two-stage requant datapath: multiply, then round/shift/saturate.
module requant_unit #(
    parameter int ACC_W  = npu_pkg::ACC_W,
    parameter int DATA_W = npu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  acc,
    input  logic [15:0]       scale,
    input  logic [4:0]        shift,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    import fixed_pkg::*;

    localparam int PW = 49;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] r;
    logic signed [PW-1:0] q;
    logic                 v1;

    // Scale is unsigned, so it enters the signed multiply zero-extended.
    assign a_ext = {{(PW-ACC_W){acc[ACC_W-1]}}, acc};
    assign s_ext = {{(PW-16){1'b0}}, scale};

    always_comb begin
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = PW'(1) << (shift - 5'd1);
        end
        r = p1 + rnd;
        q = r >>> shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            p1        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            v1        <= in_valid;
            p1        <= a_ext * s_ext;
            out_valid <= v1;
            if (v1) begin
                out_data <= DATA_W'(sat_int8(q));
            end
        end
    end

endmodule

// File: rtl/requant_engine.sv
// Requantization engine: streams int32 accumulators through the requant
// datapath into int8 activation SRAM, one element per cycle.
module requant_engine #(
    parameter int ACC_W  = npu_pkg::ACC_W,
    parameter int DATA_W = npu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       length,
    input  logic [15:0]       src_base,
    input  logic [15:0]       dst_base,
    input  logic [15:0]       scale,
    input  logic [4:0]        shift,
    output logic              acc_rd_en,
    output logic [15:0]       acc_rd_addr,
    input  logic [ACC_W-1:0]  acc_rd_data,
    output logic              sram_wr_en,
    output logic [15:0]       sram_wr_addr,
    output logic [DATA_W-1:0] sram_wr_data,
    output logic              busy,
    output logic              done
);

    import npu_pkg::*;

    requant_state_t    state;
    logic [15:0]       len_q;
    logic [15:0]       src_q;
    logic [15:0]       dst_q;
    logic [15:0]       scale_q;
    logic [4:0]        shift_q;
    logic [15:0]       rd_idx;
    logic [15:0]       wr_idx;
    logic              rd_vld;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign acc_rd_en    = (state == RUN);
    assign acc_rd_addr  = src_q + rd_idx;
    assign sram_wr_en   = out_valid;
    assign sram_wr_addr = dst_q + wr_idx;
    assign sram_wr_data = out_data;

    requant_unit #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_unit (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_vld),
        .acc       (acc_rd_data),
        .scale     (scale_q),
        .shift     (shift_q),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            scale_q <= '0;
            shift_q <= '0;
            rd_idx  <= '0;
            wr_idx  <= '0;
            rd_vld  <= 1'b0;
        end else begin
            // Read data lands one cycle after the strobe.
            rd_vld <= (state == RUN);
            if (out_valid) begin
                wr_idx <= wr_idx + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q   <= length;
                        src_q   <= src_base;
                        dst_q   <= dst_base;
                        scale_q <= scale;
                        shift_q <= shift;
                        rd_idx  <= '0;
                        wr_idx  <= '0;
                        state   <= (length == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    rd_idx <= rd_idx + 16'd1;
                    if (rd_idx == len_q - 16'd1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && wr_idx == len_q - 16'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_requant_engine.sv
// Self-checking bench for requant_engine: directed cases plus random
// commands checked cycle by cycle against an arithmetic reference model.
module tb_requant_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] length;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        acc_rd_en;
    logic [15:0] acc_rd_addr;
    logic [31:0] acc_rd_data;
    logic        sram_wr_en;
    logic [15:0] sram_wr_addr;
    logic [7:0]  sram_wr_data;
    logic        busy;
    logic        done;

    logic [31:0] acc_mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    int          nx_len;
    logic [15:0] nx_src;
    logic [15:0] nx_dst;
    logic [15:0] nx_scale;
    logic [4:0]  nx_shift;

    requant_engine dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .length       (length),
        .src_base     (src_base),
        .dst_base     (dst_base),
        .scale        (scale),
        .shift        (shift),
        .acc_rd_en    (acc_rd_en),
        .acc_rd_addr  (acc_rd_addr),
        .acc_rd_data  (acc_rd_data),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) acc_rd_data <= acc_mem[acc_rd_addr];

    // Reference: exact integer arithmetic, round half up, clamp to int8.
    function automatic logic [7:0] ref_q(input logic [31:0] acc,
                                         input logic [15:0] sc,
                                         input logic [4:0]  sh);
        int     a;
        longint p;
        longint qv;
        logic [63:0] bits;
        a = acc;
        p = longint'(a) * longint'(sc);
        if (sh != 0) p = p + (longint'(1) << (sh - 1));
        qv = p >>> sh;
        if (qv > 127) return 8'h7f;
        if (qv < -128) return 8'h80;
        bits = qv;
        return bits[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_rand(input logic [15:0] src, input int len);
        for (int i = 0; i < len; i++) begin
            logic [15:0] a;
            a = src + 16'(i);
            acc_mem[a] = $signed($urandom) >>> $urandom_range(0, 31);
        end
    endtask

    // Called at a negedge while the engine is idle.
    task automatic start(input int len, input logic [15:0] src,
                         input logic [15:0] dst, input logic [15:0] sc,
                         input logic [4:0] sh);
        length    = 16'(len);
        src_base  = src;
        dst_base  = dst;
        scale     = sc;
        shift     = sh;
        cmd_valid = 1'b1;
        @(posedge clk);
    endtask

    // Checks cycles 1 .. done+1 after acceptance, sampled at negedges.
    task automatic expect_run(input int len, input logic [15:0] src,
                              input logic [15:0] dst, input logic [15:0] sc,
                              input logic [4:0] sh, input bit hold);
        int dcyc;
        dcyc = (len == 0) ? 1 : len + 4;
        for (int k = 1; k <= dcyc + 1; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (k == 2 && hold) begin
                length    = 16'(nx_len);
                src_base  = nx_src;
                dst_base  = nx_dst;
                scale     = nx_scale;
                shift     = nx_shift;
                cmd_valid = 1'b1;
            end
            check("rd_en", 32'(acc_rd_en), 32'(k <= len));
            if (k <= len)
                check("rd_addr", 32'(acc_rd_addr), 32'(16'(src + 16'(k - 1))));
            check("wr_en", 32'(sram_wr_en), 32'(k >= 4 && k <= len + 3));
            if (k >= 4 && k <= len + 3) begin
                logic [15:0] ra;
                ra = src + 16'(k - 4);
                check("wr_addr", 32'(sram_wr_addr), 32'(16'(dst + 16'(k - 4))));
                check("wr_data", 32'(sram_wr_data), 32'(ref_q(acc_mem[ra], sc, sh)));
            end
            check("done", 32'(done), 32'(k == dcyc));
            check("cmd_ready", 32'(cmd_ready), 32'(k > dcyc));
            check("busy", 32'(busy), 32'(k <= dcyc));
        end
    endtask

    task automatic check_reset_outs();
        check("rst_rd_en", 32'(acc_rd_en), 32'd0);
        check("rst_rd_addr", 32'(acc_rd_addr), 32'd0);
        check("rst_wr_en", 32'(sram_wr_en), 32'd0);
        check("rst_wr_addr", 32'(sram_wr_addr), 32'd0);
        check("rst_wr_data", 32'(sram_wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        length    = '0;
        src_base  = '0;
        dst_base  = '0;
        scale     = '0;
        shift     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Pass-through
        acc_mem[16'h0010] = 32'd5;
        acc_mem[16'h0011] = -32'sd7;
        acc_mem[16'h0012] = 32'd0;
        acc_mem[16'h0013] = 32'd127;
        start(4, 16'h0010, 16'h0400, 16'd1, 5'd0);
        expect_run(4, 16'h0010, 16'h0400, 16'd1, 5'd0, 1'b0);

        // Rounding half up
        acc_mem[16'h0020] = 32'd3;
        acc_mem[16'h0021] = -32'sd3;
        acc_mem[16'h0022] = 32'd1;
        acc_mem[16'h0023] = -32'sd1;
        start(4, 16'h0020, 16'h0500, 16'd1, 5'd1);
        expect_run(4, 16'h0020, 16'h0500, 16'd1, 5'd1, 1'b0);
        acc_mem[16'h0030] = 32'd100;
        start(1, 16'h0030, 16'h0600, 16'd3, 5'd2);
        expect_run(1, 16'h0030, 16'h0600, 16'd3, 5'd2, 1'b0);

        // Saturation
        acc_mem[16'h0040] = 32'd1000;
        acc_mem[16'h0041] = -32'sd1000;
        acc_mem[16'h0042] = 32'h7fff_ffff;
        acc_mem[16'h0043] = 32'h8000_0000;
        start(4, 16'h0040, 16'h0700, 16'd1, 5'd0);
        expect_run(4, 16'h0040, 16'h0700, 16'd1, 5'd0, 1'b0);

        // Empty command
        start(0, 16'h0050, 16'h0800, 16'd1, 5'd0);
        expect_run(0, 16'h0050, 16'h0800, 16'd1, 5'd0, 1'b0);

        // Back-to-back with wrapping source
        fill_rand(16'hfffe, 3);
        nx_len   = 4;
        nx_src   = 16'h0100;
        nx_dst   = 16'hfffd;
        nx_scale = 16'd5;
        nx_shift = 5'd3;
        fill_rand(nx_src, nx_len);
        start(3, 16'hfffe, 16'h0900, 16'd7, 5'd4);
        expect_run(3, 16'hfffe, 16'h0900, 16'd7, 5'd4, 1'b1);
        @(posedge clk);
        expect_run(nx_len, nx_src, nx_dst, nx_scale, nx_shift, 1'b0);

        // Reset mid-run
        fill_rand(16'h0200, 8);
        start(8, 16'h0200, 16'h0a00, 16'd9, 5'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_wr_en", 32'(sram_wr_en), 32'd0);
            check("post_rst_rd_en", 32'(acc_rd_en), 32'd0);
        end
        start(8, 16'h0200, 16'h0a00, 16'd9, 5'd2);
        expect_run(8, 16'h0200, 16'h0a00, 16'd9, 5'd2, 1'b0);

        // Random commands
        for (int t = 0; t < 12; t++) begin
            int          len;
            logic [15:0] src;
            logic [15:0] dst;
            logic [15:0] sc;
            logic [4:0]  sh;
            len = $urandom_range(1, 24);
            src = 16'($urandom);
            dst = 16'($urandom);
            sc  = 16'($urandom);
            sh  = 5'($urandom_range(0, 31));
            fill_rand(src, len);
            start(len, src, dst, sc, sh);
            expect_run(len, src, dst, sc, sh, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
